// File: rtl/hazard_ctrl_if.sv
// Pipeline-to-hazard-unit bundle: ID/EX hazard sources, cache stalls, and the
// resulting per-stage control fields and performance counters.
interface hazard_ctrl_if #(
  parameter int CNT_W = 32
);
  logic             id_valid;
  logic             id_rs1_valid;
  logic             id_rs2_valid;
  logic [4:0]       id_rs1_addr;
  logic [4:0]       id_rs2_addr;
  logic             ex_valid;
  logic             ex_rd_valid;
  logic [4:0]       ex_rd_addr;
  logic             ex_is_load;
  logic             ex_branch_taken;
  logic [31:0]      ex_target_pc;
  logic             icache_stall;
  logic             dcache_stall;
  logic             pc_stall;
  logic             if_id_stall;
  logic             hazard_stall;
  logic             flush;
  logic             cache_stall;
  logic             redirect_valid;
  logic [31:0]      redirect_pc;
  logic [CNT_W-1:0] stall_cycles;
  logic [CNT_W-1:0] load_use_cnt;
  logic [CNT_W-1:0] flush_cnt;
  logic             timeout_err;

  modport master (
    output id_valid, id_rs1_valid, id_rs2_valid, id_rs1_addr, id_rs2_addr,
           ex_valid, ex_rd_valid, ex_rd_addr, ex_is_load, ex_branch_taken,
           ex_target_pc, icache_stall, dcache_stall,
    input  pc_stall, if_id_stall, hazard_stall, flush, cache_stall,
           redirect_valid, redirect_pc, stall_cycles, load_use_cnt,
           flush_cnt, timeout_err
  );

  modport slave (
    input  id_valid, id_rs1_valid, id_rs2_valid, id_rs1_addr, id_rs2_addr,
           ex_valid, ex_rd_valid, ex_rd_addr, ex_is_load, ex_branch_taken,
           ex_target_pc, icache_stall, dcache_stall,
    output pc_stall, if_id_stall, hazard_stall, flush, cache_stall,
           redirect_valid, redirect_pc, stall_cycles, load_use_cnt,
           flush_cnt, timeout_err
  );
endinterface

// File: rtl/hazard_ctrl_unit.sv
// Load-use detection and stall/flush arbitration; redirects seen while frozen
// are deferred until the freeze lifts. Includes perf counters and a watchdog.
module hazard_ctrl_unit #(
  parameter int STALL_TIMEOUT = 1024,
  parameter int CNT_W         = 32
) (
  input logic         clk,
  input logic         rst,
  hazard_ctrl_if.slave hz
);
  localparam int SR_W = $clog2(STALL_TIMEOUT + 1);
  localparam logic [SR_W-1:0] TIMEOUT_V = SR_W'(STALL_TIMEOUT);

  typedef enum logic [1:0] {
    ST_RUN         = 2'd0,
    ST_FROZEN      = 2'd1,
    ST_FROZEN_PEND = 2'd2
  } state_t;

  state_t           state_r;
  logic [31:0]      pend_pc_r;
  logic [SR_W-1:0]  stall_run_r;
  logic [CNT_W-1:0] stall_cycles_r;
  logic [CNT_W-1:0] load_use_cnt_r;
  logic [CNT_W-1:0] flush_cnt_r;
  logic             timeout_err_r;

  logic             cache_stall_s;
  logic             load_use_s;
  logic             flush_s;
  logic             hazard_stall_s;
  logic [31:0]      redirect_pc_s;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic ev);
    if (ev && (v != {CNT_W{1'b1}})) begin
      return v + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      return v;
    end
  endfunction

  assign cache_stall_s = hz.icache_stall | hz.dcache_stall;

  assign load_use_s = hz.id_valid & hz.ex_valid & hz.ex_is_load & hz.ex_rd_valid
                    & (hz.ex_rd_addr != 5'd0)
                    & ((hz.id_rs1_valid & (hz.id_rs1_addr == hz.ex_rd_addr))
                     | (hz.id_rs2_valid & (hz.id_rs2_addr == hz.ex_rd_addr)));

  // Flush/redirect selection; a deferred redirect fires the cycle the freeze lifts.
  always_comb begin
    flush_s       = 1'b0;
    redirect_pc_s = hz.ex_target_pc;
    case (state_r)
      ST_RUN, ST_FROZEN: begin
        if (!cache_stall_s && hz.ex_branch_taken) begin
          flush_s = 1'b1;
        end else begin
          flush_s = 1'b0;
        end
      end
      ST_FROZEN_PEND: begin
        flush_s       = !cache_stall_s;
        redirect_pc_s = pend_pc_r;
      end
      default: begin
        flush_s       = 1'b0;
        redirect_pc_s = hz.ex_target_pc;
      end
    endcase
  end

  assign hazard_stall_s = load_use_s & !cache_stall_s & !flush_s;

  // FSM, pending redirect target, watchdog and perf counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r        <= ST_RUN;
      pend_pc_r      <= 32'd0;
      stall_run_r    <= {SR_W{1'b0}};
      stall_cycles_r <= {CNT_W{1'b0}};
      load_use_cnt_r <= {CNT_W{1'b0}};
      flush_cnt_r    <= {CNT_W{1'b0}};
      timeout_err_r  <= 1'b0;
    end else begin
      case (state_r)
        ST_RUN, ST_FROZEN: begin
          if (cache_stall_s && hz.ex_branch_taken) begin
            pend_pc_r <= hz.ex_target_pc;
            state_r   <= ST_FROZEN_PEND;
          end else if (cache_stall_s) begin
            state_r <= ST_FROZEN;
          end else begin
            state_r <= ST_RUN;
          end
        end
        // EX is frozen here, so later branch indications repeat the same instruction
        ST_FROZEN_PEND: begin
          if (!cache_stall_s) begin
            state_r <= ST_RUN;
          end else begin
            state_r <= ST_FROZEN_PEND;
          end
        end
        default: state_r <= ST_RUN;
      endcase

      if (cache_stall_s) begin
        if (stall_run_r != TIMEOUT_V) begin
          stall_run_r <= stall_run_r + SR_W'(1);
        end else begin
          stall_run_r <= stall_run_r;
        end
        if (stall_run_r >= (TIMEOUT_V - SR_W'(1))) begin
          timeout_err_r <= 1'b1;
        end else begin
          timeout_err_r <= timeout_err_r;
        end
      end else begin
        stall_run_r   <= {SR_W{1'b0}};
        timeout_err_r <= timeout_err_r;
      end

      stall_cycles_r <= sat_inc(stall_cycles_r, cache_stall_s);
      load_use_cnt_r <= sat_inc(load_use_cnt_r, hazard_stall_s);
      flush_cnt_r    <= sat_inc(flush_cnt_r, flush_s);
    end
  end

  assign hz.cache_stall    = cache_stall_s;
  assign hz.hazard_stall   = hazard_stall_s;
  assign hz.flush          = flush_s;
  assign hz.redirect_valid = flush_s;
  assign hz.redirect_pc    = redirect_pc_s;
  assign hz.pc_stall       = hazard_stall_s | cache_stall_s;
  assign hz.if_id_stall    = hazard_stall_s | cache_stall_s;
  assign hz.stall_cycles   = stall_cycles_r;
  assign hz.load_use_cnt   = load_use_cnt_r;
  assign hz.flush_cnt      = flush_cnt_r;
  assign hz.timeout_err    = timeout_err_r;
endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Directed bench for hazard_ctrl_unit with a short watchdog timeout.
module tb_hazard_ctrl_unit;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;

  hazard_ctrl_if #(.CNT_W(32)) ifc ();

  hazard_ctrl_unit #(.STALL_TIMEOUT(4), .CNT_W(32)) dut (
    .clk (clk),
    .rst (rst),
    .hz  (ifc.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    ifc.id_valid = 1'b0; ifc.id_rs1_valid = 1'b0; ifc.id_rs2_valid = 1'b0;
    ifc.id_rs1_addr = 5'd0; ifc.id_rs2_addr = 5'd0;
    ifc.ex_valid = 1'b0; ifc.ex_rd_valid = 1'b0; ifc.ex_rd_addr = 5'd0;
    ifc.ex_is_load = 1'b0; ifc.ex_branch_taken = 1'b0; ifc.ex_target_pc = 32'd0;
    ifc.icache_stall = 1'b0; ifc.dcache_stall = 1'b0;
  endtask

  task automatic load_use(input logic [4:0] rd, input logic [4:0] rs2);
    ifc.ex_valid = 1'b1; ifc.ex_is_load = 1'b1; ifc.ex_rd_valid = 1'b1; ifc.ex_rd_addr = rd;
    ifc.id_valid = 1'b1; ifc.id_rs2_valid = 1'b1; ifc.id_rs2_addr = rs2;
  endtask

  initial begin
    idle();
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    #1;
    chk("rst_stall_cycles", ifc.stall_cycles, 32'd0);
    chk("rst_load_use_cnt", ifc.load_use_cnt, 32'd0);
    chk("rst_flush_cnt", ifc.flush_cnt, 32'd0);
    chk("rst_timeout_err", {31'd0, ifc.timeout_err}, 32'd0);
    chk("rst_flush", {31'd0, ifc.flush}, 32'd0);
    chk("rst_pc_stall", {31'd0, ifc.pc_stall}, 32'd0);

    // Load x5, ID reads rs2=x5
    load_use(5'd5, 5'd5);
    #1;
    chk("lu_hazard_stall", {31'd0, ifc.hazard_stall}, 32'd1);
    chk("lu_pc_stall", {31'd0, ifc.pc_stall}, 32'd1);
    chk("lu_if_id_stall", {31'd0, ifc.if_id_stall}, 32'd1);
    chk("lu_flush", {31'd0, ifc.flush}, 32'd0);
    tick();
    idle();
    #1;
    chk("lu_clear", {31'd0, ifc.hazard_stall}, 32'd0);
    chk("lu_cnt", ifc.load_use_cnt, 32'd1);

    // Load into x0, ID reads x0
    load_use(5'd0, 5'd0);
    ifc.id_rs1_valid = 1'b1;
    #1;
    chk("x0_hazard_stall", {31'd0, ifc.hazard_stall}, 32'd0);
    chk("x0_pc_stall", {31'd0, ifc.pc_stall}, 32'd0);
    tick();
    idle();
    #1;
    chk("x0_cnt", ifc.load_use_cnt, 32'd1);

    // Taken branch, no stall
    ifc.ex_valid = 1'b1; ifc.ex_branch_taken = 1'b1; ifc.ex_target_pc = 32'h0000_0100;
    #1;
    chk("br_flush", {31'd0, ifc.flush}, 32'd1);
    chk("br_redirect_valid", {31'd0, ifc.redirect_valid}, 32'd1);
    chk("br_redirect_pc", ifc.redirect_pc, 32'h0000_0100);
    chk("br_pc_stall", {31'd0, ifc.pc_stall}, 32'd0);
    tick();
    idle();
    #1;
    chk("br_flush_cnt", ifc.flush_cnt, 32'd1);
    chk("br_flush_after", {31'd0, ifc.flush}, 32'd0);

    // dcache stall 3 cycles with branches to 0x200 then 0x300
    ifc.dcache_stall = 1'b1; ifc.ex_branch_taken = 1'b1; ifc.ex_target_pc = 32'h0000_0200;
    #1;
    chk("ds1_flush", {31'd0, ifc.flush}, 32'd0);
    chk("ds1_cache_stall", {31'd0, ifc.cache_stall}, 32'd1);
    chk("ds1_pc_stall", {31'd0, ifc.pc_stall}, 32'd1);
    tick();
    ifc.ex_target_pc = 32'h0000_0300;
    #1;
    chk("ds2_flush", {31'd0, ifc.flush}, 32'd0);
    chk("ds2_redirect_pc", ifc.redirect_pc, 32'h0000_0200);
    tick();
    ifc.ex_branch_taken = 1'b0;
    #1;
    chk("ds3_flush", {31'd0, ifc.flush}, 32'd0);
    tick();
    ifc.dcache_stall = 1'b0; ifc.ex_target_pc = 32'h0000_0300;
    #1;
    chk("ds_rel_flush", {31'd0, ifc.flush}, 32'd1);
    chk("ds_rel_redirect_pc", ifc.redirect_pc, 32'h0000_0200);
    chk("ds_stall_cycles", ifc.stall_cycles, 32'd3);
    tick();
    idle();
    #1;
    chk("ds_flush_cnt", ifc.flush_cnt, 32'd2);
    chk("ds_flush_after", {31'd0, ifc.flush}, 32'd0);
    chk("ds_no_timeout", {31'd0, ifc.timeout_err}, 32'd0);

    // Load-use together with a taken branch
    load_use(5'd7, 5'd7);
    ifc.ex_branch_taken = 1'b1; ifc.ex_target_pc = 32'h0000_0480;
    #1;
    chk("lub_flush", {31'd0, ifc.flush}, 32'd1);
    chk("lub_hazard_stall", {31'd0, ifc.hazard_stall}, 32'd0);
    chk("lub_pc_stall", {31'd0, ifc.pc_stall}, 32'd0);
    tick();
    idle();
    #1;
    chk("lub_flush_cnt", ifc.flush_cnt, 32'd3);
    chk("lub_lu_cnt", ifc.load_use_cnt, 32'd1);

    // icache stall for 6 cycles against a timeout of 4
    for (int i = 0; i < 6; i++) begin
      ifc.icache_stall = 1'b1;
      #1;
      chk($sformatf("ic%0d_flush", i), {31'd0, ifc.flush}, 32'd0);
      chk($sformatf("ic%0d_timeout", i), {31'd0, ifc.timeout_err}, (i >= 4) ? 32'd1 : 32'd0);
      tick();
    end
    ifc.icache_stall = 1'b0;
    #1;
    chk("ic_end_timeout", {31'd0, ifc.timeout_err}, 32'd1);
    chk("ic_stall_cycles", ifc.stall_cycles, 32'd9);
    tick();
    chk("ic_sticky_timeout", {31'd0, ifc.timeout_err}, 32'd1);

    // Reset while a redirect is pending
    ifc.dcache_stall = 1'b1; ifc.ex_branch_taken = 1'b1; ifc.ex_target_pc = 32'h0000_0400;
    tick();
    ifc.ex_branch_taken = 1'b0;
    #1;
    chk("pend_redirect_pc", ifc.redirect_pc, 32'h0000_0400);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    ifc.dcache_stall = 1'b0; ifc.ex_target_pc = 32'h0000_0500;
    #1;
    chk("rst2_flush", {31'd0, ifc.flush}, 32'd0);
    chk("rst2_redirect_pc", ifc.redirect_pc, 32'h0000_0500);
    chk("rst2_stall_cycles", ifc.stall_cycles, 32'd0);
    chk("rst2_load_use_cnt", ifc.load_use_cnt, 32'd0);
    chk("rst2_flush_cnt", ifc.flush_cnt, 32'd0);
    chk("rst2_timeout_err", {31'd0, ifc.timeout_err}, 32'd0);
    tick();
    chk("rst2_flush_cnt_after", ifc.flush_cnt, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
